// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed multiply (radix-2 Booth) / divide (restoring) feeding HI/LO
// Optional unsigned multu/divu on op[1] when UNSIGNED_OPS_EN is defined.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               is_div;
   logic               uns;
   logic               a_neg;
   logic               b_neg;
   logic               b_top;
   logic               dz_pend;
   logic               qm1;
   logic [WIDTH+1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [WIDTH+1:0]   mcand;

   logic               op_uns;
   logic               in_a_neg;
   logic               in_b_neg;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;

`ifdef UNSIGNED_OPS_EN
   assign op_uns = op[1];
`else
   logic unused_op1;
   assign op_uns     = 1'b0;
   assign unused_op1 = op[1];
`endif

   assign in_a_neg = ~op_uns & a[WIDTH-1];
   assign in_b_neg = ~op_uns & b[WIDTH-1];
   assign abs_a    = in_a_neg ? -a : a;
   assign abs_b    = in_b_neg ? -b : b;

   logic [WIDTH+1:0]   sum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH+1:0]   trial;
   logic [WIDTH+1:0]   nxt_hi;
   logic [WIDTH-1:0]   nxt_lo;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   always_comb begin
      sum = acc_hi;
      case ({acc_lo[0], qm1})
         2'b01:   sum = acc_hi + mcand;
         2'b10:   sum = acc_hi - mcand;
         default: sum = acc_hi;
      endcase
      shifted = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
      trial   = {1'b0, shifted} - mcand;

      if (is_div) begin
         if (!trial[WIDTH+1]) begin
            nxt_hi = trial;
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            nxt_hi = {1'b0, shifted};
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
         end
         res_lo = (a_neg ^ b_neg) ? -nxt_lo : nxt_lo;
         res_hi = a_neg ? -nxt_hi[WIDTH-1:0] : nxt_hi[WIDTH-1:0];
      end else begin
         nxt_hi = {sum[WIDTH+1], sum[WIDTH+1:1]};
         nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
         res_lo = nxt_lo;
         // Booth treats b as signed; an unsigned b with its MSB set needs a<<WIDTH added back.
         res_hi = nxt_hi[WIDTH-1:0] + ((uns && b_top) ? mcand[WIDTH-1:0] : '0);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         is_div   <= 1'b0;
         uns      <= 1'b0;
         a_neg    <= 1'b0;
         b_neg    <= 1'b0;
         b_top    <= 1'b0;
         dz_pend  <= 1'b0;
         qm1      <= 1'b0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         mcand    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  div_zero <= 1'b0;
                  is_div   <= op[0];
                  uns      <= op_uns;
                  a_neg    <= in_a_neg;
                  b_neg    <= in_b_neg;
                  b_top    <= b[WIDTH-1];
                  qm1      <= 1'b0;
                  acc_hi   <= '0;
                  cnt      <= CNT_W'(WIDTH);
                  dz_pend  <= 1'b0;
                  if (op[0]) begin
                     acc_lo <= abs_a;
                     mcand  <= {2'b00, abs_b};
                     // Divide-by-zero skips the iterations but still spends one busy cycle.
                     if (b == '0) begin
                        dz_pend <= 1'b1;
                        cnt     <= CNT_W'(1);
                     end
                  end else begin
                     acc_lo <= b;
                     mcand  <= op_uns ? {2'b00, a} : {{2{a[WIDTH-1]}}, a};
                  end
               end
            end
            RUN: begin
               if (!dz_pend) begin
                  acc_hi <= nxt_hi;
                  acc_lo <= nxt_lo;
                  qm1    <= acc_lo[0];
               end
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  dz_pend <= 1'b0;
                  if (dz_pend) begin
                     div_zero <= 1'b1;
                  end else begin
                     hi <= res_hi;
                     lo <= res_lo;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit against an arithmetic model
// Honours UNSIGNED_OPS_EN the same way as the design.
module tb_mult_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         div_zero;

   int checks = 0;
   int fails  = 0;

   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   logic         m_dz = 1'b0;
   int           m_lat;
   int           lat;
   int           busy_cnt;
   logic         got_done;

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      logic          u;
      longint        sx, sy, q, r;
      logic [2*W-1:0] p;
`ifdef UNSIGNED_OPS_EN
      u = o[1];
`else
      u = 1'b0;
`endif
      m_dz  = 1'b0;
      m_lat = W + 1;
      if (!o[0]) begin
         if (u) p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
         else   p = 64'(longint'($signed(x)) * longint'($signed(y)));
         m_hi = p[2*W-1:W];
         m_lo = p[W-1:0];
      end else if (y == '0) begin
         m_dz  = 1'b1;
         m_lat = 2;
      end else begin
         sx = u ? longint'(x) : longint'($signed(x));
         sy = u ? longint'(y) : longint'($signed(y));
         q = sx / sy;
         r = sx % sy;
         m_lo = q[W-1:0];
         m_hi = r[W-1:0];
      end
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      model(o, x, y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1;
      start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
      lat = 0; busy_cnt = 0; got_done = 1'b0;
      for (int k = 1; k <= W + 10 && !got_done; k++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            got_done = 1'b1;
            lat = k;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (hi !== '0) begin fails++; $display("FAIL reset_hi got %h want 0", hi); end
      checks++; if (lo !== '0) begin fails++; $display("FAIL reset_lo got %h want 0", lo); end
      checks++; if (div_zero !== 1'b0) begin fails++; $display("FAIL reset_dz got %b want 0", div_zero); end
      reset = 1'b1;
   endtask

   task automatic test_directed();
      run_op(2'b00, 32'd7, -32'sd3);
      checks++; if (!got_done || lat != 33) begin fails++; $display("FAIL mult_latency got %0d want 33", lat); end
      checks++; if (busy_cnt != 33) begin fails++; $display("FAIL mult_busy got %0d want 33", busy_cnt); end
      checks++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_hi got %h want ffffffff", hi); end
      checks++; if (lo !== 32'hFFFFFFEB) begin fails++; $display("FAIL mult_lo got %h want ffffffeb", lo); end

      run_op(2'b01, -32'sd7, 32'd2);
      checks++; if (!got_done || lat != 33) begin fails++; $display("FAIL div_latency got %0d want 33", lat); end
      checks++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_lo got %h want fffffffd", lo); end
      checks++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_hi got %h want ffffffff", hi); end
      checks++; if (div_zero !== 1'b0) begin fails++; $display("FAIL div_dz got %b want 0", div_zero); end

      run_op(2'b01, 32'd5, 32'd2);
      checks++; if (hi !== 32'd1 || lo !== 32'd2) begin fails++; $display("FAIL div_prep got %h/%h want 1/2", hi, lo); end
      run_op(2'b01, 32'd5, 32'd0);
      checks++; if (!got_done || lat != 2) begin fails++; $display("FAIL dz_latency got %0d want 2", lat); end
      checks++; if (busy_cnt != 2) begin fails++; $display("FAIL dz_busy got %0d want 2", busy_cnt); end
      checks++; if (div_zero !== 1'b1) begin fails++; $display("FAIL dz_flag got %b want 1", div_zero); end
      checks++; if (hi !== 32'd1 || lo !== 32'd2) begin fails++; $display("FAIL dz_hold got %h/%h want 1/2", hi, lo); end
   endtask

   task automatic test_overflow_busy_start();
      int ndone = 0;
      int k_done = 0;
      model(2'b01, 32'h80000000, 32'hFFFFFFFF);
      @(negedge clk);
      start = 1'b1; op = 2'b01; a = 32'h80000000; b = 32'hFFFFFFFF;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= W + 10 && ndone == 0; k++) begin
         @(negedge clk);
         if (k == 5) begin start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4; end
         if (k == 6) start = 1'b0;
         if (done) begin ndone++; k_done = k; end
      end
      checks++; if (k_done != 33) begin fails++; $display("FAIL ovf_latency got %0d want 33", k_done); end
      checks++; if (lo !== 32'h80000000 || hi !== '0) begin fails++; $display("FAIL ovf_result got %h/%h want 0/80000000", hi, lo); end
      checks++; if (div_zero !== 1'b0) begin fails++; $display("FAIL dz_cleared got %b want 0", div_zero); end
      start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL done_cycle_start got busy=%b want 0", busy); end
      repeat (4) begin
         @(negedge clk);
         if (done) ndone++;
      end
      checks++; if (ndone != 1) begin fails++; $display("FAIL single_done got %0d want 1", ndone); end
      checks++; if (lo !== 32'h80000000) begin fails++; $display("FAIL ovf_hold got %h want 80000000", lo); end
   endtask

   task automatic test_reset_mid();
      int ndone = 0;
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy); end
      checks++; if (hi !== '0 || lo !== '0) begin fails++; $display("FAIL rst_mid_hilo got %h/%h want 0/0", hi, lo); end
      repeat (3) begin
         @(negedge clk);
         if (done) ndone++;
      end
      reset = 1'b1;
      repeat (W + 5) begin
         @(negedge clk);
         if (done) ndone++;
      end
      checks++; if (ndone != 0) begin fails++; $display("FAIL rst_mid_done got %0d want 0", ndone); end
      m_hi = '0; m_lo = '0;
      run_op(2'b00, 32'd3, 32'd4);
      checks++; if (!got_done || lo !== 32'd12 || hi !== '0) begin fails++; $display("FAIL after_rst got %h/%h want 0/c", hi, lo); end
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 32'd1;
         2:       return '1;
         3:       return 32'h80000000;
         4:       return 32'h7FFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic test_random();
      logic [1:0]   o;
      logic [W-1:0] x, y;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         x = pick();
         y = pick();
         run_op(o, x, y);
         checks++; if (!got_done || lat != m_lat) begin fails++; $display("FAIL rnd_latency op=%b a=%h b=%h got %0d want %0d", o, x, y, lat, m_lat); end
         checks++; if (hi !== m_hi) begin fails++; $display("FAIL rnd_hi op=%b a=%h b=%h got %h want %h", o, x, y, hi, m_hi); end
         checks++; if (lo !== m_lo) begin fails++; $display("FAIL rnd_lo op=%b a=%h b=%h got %h want %h", o, x, y, lo, m_lo); end
         checks++; if (div_zero !== m_dz) begin fails++; $display("FAIL rnd_dz op=%b a=%h b=%h got %b want %b", o, x, y, div_zero, m_dz); end
      end
   endtask

   task automatic test_unsigned();
      run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF);
`ifdef UNSIGNED_OPS_EN
      checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'd1) begin fails++; $display("FAIL multu got %h/%h want fffffffe/1", hi, lo); end
`else
      checks++; if (hi !== '0 || lo !== 32'd1) begin fails++; $display("FAIL multu_off got %h/%h want 0/1", hi, lo); end
`endif
      checks++; if (!got_done || lat != 33) begin fails++; $display("FAIL multu_latency got %0d want 33", lat); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_overflow_busy_start();
      test_reset_mid();
      test_random();
      test_unsigned();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
